// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder with carry in/out, split into STAGES registered carry-chain segments behind a valid/ready handshake with global stall
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake; in_ready = !out_valid || out_ready
//   a, b, cin           operands and carry in
//   out_valid, out_ready result handshake
//   sum, cout           (a + b + cin) mod 2^WIDTH and carry out of the MSB
//   ovf                 two's-complement overflow, present only with PIPELINED_ADDER_OVF_EN
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = WIDTH / STAGES;
    logic advance;
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [STAGES-1:0] c_q, v_q;
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic [WIDTH-1:0] nx_s [STAGES];
    logic [STAGES-1:0] st_c, st_v;
    logic [CW:0] chunk [STAGES];
    assign advance   = !v_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    // Stage i sees the inputs for i == 0, otherwise the registers of stage i-1,
    // and adds chunk i on top of the lower sum chunks already produced.
    always_comb begin
        st_a[0] = a;
        st_b[0] = b;
        st_s[0] = '0;
        st_c[0] = cin;
        st_v[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            st_a[i] = a_q[i-1];
            st_b[i] = b_q[i-1];
            st_s[i] = s_q[i-1];
            st_c[i] = c_q[i-1];
            st_v[i] = v_q[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            chunk[i] = {1'b0, st_a[i][i*CW +: CW]} + {1'b0, st_b[i][i*CW +: CW]} + {{CW{1'b0}}, st_c[i]};
            nx_s[i] = st_s[i];
            nx_s[i][i*CW +: CW] = chunk[i][CW-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else if (advance) begin
            v_q <= st_v;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= st_a[i];
                b_q[i] <= st_b[i];
                s_q[i] <= nx_s[i];
                c_q[i] <= chunk[i][CW];
            end
        end
    end
`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_q;
    // Operand sign bits travel with the pending upper chunks into the last stage.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (advance)
            ovf_q <= (st_a[STAGES-1][WIDTH-1] == st_b[STAGES-1][WIDTH-1]) &&
                     (nx_s[STAGES-1][WIDTH-1] != st_a[STAGES-1][WIDTH-1]);
    end
    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed scoreboard bench for pipelined_adder
module tb_pipelined_adder;
    localparam int STG = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;
    logic v1, r1, a1, b1, c1, ov1, or1, s1, co1;
`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf, ovf1;
`endif
    pipelined_adder #(.WIDTH(16), .STAGES(STG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );
    pipelined_adder #(.WIDTH(1), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .a(a1), .b(b1), .cin(c1), .out_valid(ov1), .out_ready(or1),
        .sum(s1),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(ovf1),
`endif
        .cout(co1)
    );
    int checks = 0;
    int errors = 0;
    logic [17:0] q [$];
    logic hold;
    logic [17:0] held;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Reference: one plain 17-bit add, plus the sign-based overflow rule.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        t = {1'b0, x} + {1'b0, y} + {16'd0, c};
        return {(x[15] == y[15]) && (t[15] != x[15]), t};
    endfunction
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic ordy);
        logic [17:0] e;
        in_valid = iv;
        a = ia;
        b = ib;
        cin = ic;
        out_ready = ordy;
        #1;
        if (hold) chk("hold", {out_valid, cout, sum}, held);
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("sum", sum, e[15:0]);
                chk("cout", cout, e[16]);
`ifdef PIPELINED_ADDER_OVF_EN
                chk("ovf", ovf, e[17]);
`endif
            end
        end
        if (!rst && in_valid && in_ready) q.push_back(model(ia, ib, ic));
        hold = !rst && out_valid && !out_ready;
        held = {out_valid, cout, sum};
        @(posedge clk);
        @(negedge clk);
        if (rst) q.delete();
    endtask
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [1:0] r;
    logic iv_p;
    logic [15:0] a_p, b_p;
    logic c_p;
    initial begin
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
        hold = 0; held = 0;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0; or1 = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_w1", {ov1, co1, s1}, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v1 = 1;
            {a1, b1} = 2'(i);
            @(posedge clk);
            @(negedge clk);
            r = {1'b0, a1} + {1'b0, b1};
            chk("w1_valid", ov1, 1);
            chk("w1_sum_cout", {co1, s1}, r);
        end
        v1 = 0;
        step(1, 16'hFFFF, 16'h0001, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            chk("latency", out_valid, i == STG);
            step(0, 0, 0, 0, 1);
        end
        va = '{16'h0001, 16'h00FF, 16'h0FFF, 16'h1234};
        vb = '{16'h0002, 16'h0001, 16'h0001, 16'h4321};
        for (int i = 0; i < 4; i++) step(1, va[i], vb[i], 0, 1);
        for (int i = 4; i <= 8; i++) begin
            chk("stream_valid", out_valid, i < 8);
            step(0, 0, 0, 0, 1);
        end
        step(1, 16'h7FFF, 16'h0000, 1, 1);
        step(1, 16'hFFFF, 16'h0001, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 16'(i * 16'h1111 + 16'h0F0F), 16'(16'hF0F0 - i), i[0], 1);
        chk("stall_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 16'hABCD, 16'h5432, 1, 0);
            chk("stall_ready", in_ready, 0);
        end
        for (int i = 0; i < 8; i++) step(i == 0, 16'hABCD, 16'h5432, 1, 1);
        chk("drain_stall", q.size(), 0);
        step(1, 16'h1111, 16'h2222, 0, 1);
        step(1, 16'h3333, 16'h4444, 1, 1);
        rst = 1'b1;
        step(0, 0, 0, 0, 1);
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        iv_p = 0; a_p = 0; b_p = 0; c_p = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!(iv_p && !in_ready)) begin
                iv_p = ($urandom_range(0, 2) != 0);
                a_p = 16'($urandom);
                b_p = 16'($urandom);
                c_p = 1'($urandom);
            end
            step(iv_p, a_p, b_p, c_p, $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
        chk("drain_random", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
